// File: rtl/ram2_ctrl_pkg.sv
// rtl/ram2_ctrl_pkg.sv - shared types and constants for the RAM2 SRAM controller
//
// Purpose : FSM state encoding and the pipeline-side strobe levels used by ram2_ctrl.
// Ports   : none (package).

package ram2_ctrl_pkg;

   // 3-bit state encoding for the SRAM access sequencer
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4
   } ram2_state_t;

   // Active levels of the MEM-stage request strobes
   localparam logic RAM_CHIP_ENABLE  = 1'b1;
   localparam logic RAM_READ_ENABLE  = 1'b1;
   localparam logic RAM_WRITE_ENABLE = 1'b1;

   localparam logic [15:0] ZERO_WORD = 16'h0000;

   // Width of the shared read-wait / write-pulse cycle counter
   localparam int CNT_W = 8;

   // True for the states in which the controller owns the SRAM data bus
   function automatic logic is_write_state(input ram2_state_t s);
      return (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
   endfunction

endpackage

// File: rtl/ram2_ctrl.sv
// rtl/ram2_ctrl.sv - RAM2 async SRAM initiator serving instruction fetch and MEM load/store
//
// Purpose : Sequences reads and writes on a single async SRAM bus on behalf of the
//           pipeline. MEM-stage accesses take priority over instruction fetch; the
//           pipeline is stalled while an access is in flight.
// Ports   :
//   clk, rst          system clock, synchronous active-high reset
//   pc                fetch address
//   inst_o/inst_valid last fetched word / 1-cycle pulse when it was updated
//   mem_ce/re/we      MEM-stage enable and read/write requests
//   mem_addr_i        MEM access address
//   mem_data_i        store data
//   mem_data_o        load data, held until the next completed load
//   mem_done          1-cycle pulse when a MEM access completes
//   stall_req         freeze IF..MEM while high
//   ram2_addr         SRAM address (CPU address zero-extended)
//   ram2_data         SRAM data bus, driven only during the write sequence
//   ram2_en_n/oe_n/we_n  SRAM strobes, active-low

module ram2_ctrl
   import ram2_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 18,
   parameter int RD_WAIT  = 1,
   parameter int WR_PULSE = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       pc,
   output logic [15:0]       inst_o,
   output logic              inst_valid,
   input  logic              mem_ce,
   input  logic              mem_re,
   input  logic              mem_we,
   input  logic [15:0]       mem_addr_i,
   input  logic [15:0]       mem_data_i,
   output logic [15:0]       mem_data_o,
   output logic              mem_done,
   output logic              stall_req,
   output logic [ADDR_W-1:0] ram2_addr,
   inout  wire  [15:0]       ram2_data,
   output logic              ram2_en_n,
   output logic              ram2_oe_n,
   output logic              ram2_we_n
);

   ram2_state_t       r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_is_mem;      // current read belongs to MEM (else IF)
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_wdata;
   logic              r_drive;
   logic              r_en_n;
   logic              r_oe_n;
   logic              r_we_n;
   logic [15:0]       r_inst;
   logic              r_inst_valid;
   logic [15:0]       r_mem_data;
   logic              r_mem_done;

   logic              w_mem_wr;
   logic              w_mem_rd;
   logic              w_mem_req;
   logic [15:0]       w_acc_addr;

   assign w_mem_wr  = (mem_ce == RAM_CHIP_ENABLE) && (mem_we == RAM_WRITE_ENABLE);
   assign w_mem_rd  = (mem_ce == RAM_CHIP_ENABLE) && (mem_re == RAM_READ_ENABLE);
   assign w_mem_req = w_mem_wr || w_mem_rd;

   // Address accepted in IDLE: MEM wins over the fetch
   assign w_acc_addr = w_mem_req ? mem_addr_i : pc;

   // Freeze in the request cycle too, so the MEM stage holds its operands until done.
   // The done cycle itself is exempt so the pipeline advances on that edge.
   assign stall_req = (r_state != ST_IDLE) || (w_mem_req && !r_mem_done);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_is_mem     <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= ZERO_WORD;
         r_drive      <= 1'b0;
         r_en_n       <= 1'b1;
         r_oe_n       <= 1'b1;
         r_we_n       <= 1'b1;
         r_inst       <= ZERO_WORD;
         r_inst_valid <= 1'b0;
         r_mem_data   <= ZERO_WORD;
         r_mem_done   <= 1'b0;
      end else begin
         r_inst_valid <= 1'b0;
         r_mem_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Skipped in the done cycle: a request still held there is the one just served
               if (!r_mem_done) begin
                  r_addr <= {{(ADDR_W-16){1'b0}}, w_acc_addr};
                  r_en_n <= 1'b0;
                  if (w_mem_wr) begin
                     r_wdata <= mem_data_i;
                     r_drive <= 1'b1;
                     r_state <= ST_WR_SETUP;
                  end else begin
                     r_is_mem <= w_mem_rd;
                     r_cnt    <= CNT_W'(RD_WAIT);
                     r_oe_n   <= 1'b0;
                     r_state  <= ST_READ;
                  end
               end
            end

            ST_READ: begin
               if (r_cnt == '0) begin
                  if (r_is_mem) begin
                     r_mem_data <= ram2_data;
                     r_mem_done <= 1'b1;
                  end else begin
                     r_inst       <= ram2_data;
                     r_inst_valid <= 1'b1;
                  end
                  r_en_n  <= 1'b1;
                  r_oe_n  <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            ST_WR_SETUP: begin
               r_we_n  <= 1'b0;
               r_cnt   <= CNT_W'(WR_PULSE - 1);
               r_state <= ST_WR_PULSE;
            end

            ST_WR_PULSE: begin
               if (r_cnt == '0) begin
                  r_we_n  <= 1'b1;
                  r_state <= ST_WR_HOLD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            ST_WR_HOLD: begin
               // Data stays on the bus through this cycle for hold time after we_n rises
               r_drive    <= 1'b0;
               r_en_n     <= 1'b1;
               r_mem_done <= 1'b1;
               r_state    <= ST_IDLE;
            end

            default: begin
               r_drive <= 1'b0;
               r_en_n  <= 1'b1;
               r_oe_n  <= 1'b1;
               r_we_n  <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // r_drive is only ever set on entry to the write sequence, which keeps oe_n high
   assign ram2_data = (r_drive && is_write_state(r_state)) ? r_wdata : 16'bz;

   assign ram2_addr  = r_addr;
   assign ram2_en_n  = r_en_n;
   assign ram2_oe_n  = r_oe_n;
   assign ram2_we_n  = r_we_n;
   assign inst_o     = r_inst;
   assign inst_valid = r_inst_valid;
   assign mem_data_o = r_mem_data;
   assign mem_done   = r_mem_done;

endmodule

// File: tb/tb_ram2_ctrl.sv
// tb/tb_ram2_ctrl.sv - self-checking bench for ram2_ctrl with an async SRAM model

module tb_ram2_ctrl;

   localparam int ADDR_W   = 18;
   localparam int RD_WAIT  = 1;
   localparam int WR_PULSE = 1;
   localparam int RD_LAT   = RD_WAIT + 2;
   localparam int WR_LAT   = WR_PULSE + 3;

   logic              clk;
   logic              rst;
   logic [15:0]       pc;
   logic [15:0]       inst_o;
   logic              inst_valid;
   logic              mem_ce;
   logic              mem_re;
   logic              mem_we;
   logic [15:0]       mem_addr_i;
   logic [15:0]       mem_data_i;
   logic [15:0]       mem_data_o;
   logic              mem_done;
   logic              stall_req;
   logic [ADDR_W-1:0] ram2_addr;
   wire  [15:0]       ram2_data;
   logic              ram2_en_n;
   logic              ram2_oe_n;
   logic              ram2_we_n;

   int n_cmp = 0;
   int n_bad = 0;

   ram2_ctrl #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)) dut (
      .clk(clk), .rst(rst), .pc(pc), .inst_o(inst_o), .inst_valid(inst_valid),
      .mem_ce(mem_ce), .mem_re(mem_re), .mem_we(mem_we),
      .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
      .mem_done(mem_done), .stall_req(stall_req), .ram2_addr(ram2_addr),
      .ram2_data(ram2_data), .ram2_en_n(ram2_en_n), .ram2_oe_n(ram2_oe_n),
      .ram2_we_n(ram2_we_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Power-up SRAM contents: a few fixed words, the rest a pattern of the address
   function automatic logic [15:0] init_pat(input logic [15:0] a);
      case (a)
         16'h0010: return 16'h6911;
         16'h0123: return 16'hBEEF;
         default:  return a ^ 16'h5A5A;
      endcase
   endfunction

   // SRAM model: drives the bus while selected with oe_n low, latches while we_n low
   logic [15:0] sram [0:65535];
   bit          written [0:65535];
   logic [15:0] sram_q;

   always_comb begin
      sram_q = written[ram2_addr[15:0]] ? sram[ram2_addr[15:0]] : init_pat(ram2_addr[15:0]);
   end

   assign ram2_data = (!ram2_en_n && !ram2_oe_n && ram2_we_n) ? sram_q : 16'bz;

   always @(posedge clk) begin
      if (!ram2_en_n && !ram2_we_n) begin
         sram[ram2_addr[15:0]]    <= ram2_data;
         written[ram2_addr[15:0]] <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Always-on checks: strobe exclusivity and every fetched word
   always @(negedge clk) begin
      if (!rst) begin
         check("oe_we_overlap", {31'd0, (ram2_oe_n === 1'b0 && ram2_we_n === 1'b0)}, 32'd0);
         if (inst_valid === 1'b1)
            check("fetch_word", {16'd0, inst_o}, {16'd0, init_pat(pc)});
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      mem_ce = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
      mem_addr_i = 16'h0; mem_data_i = 16'h0;
   endtask

   // Leaves the caller 1 ns after the first post-reset edge, i.e. at the start of cycle 0
   task automatic reset_dut();
      rst = 1'b1;
      idle_inputs();
      nxt();
      nxt();
      rst = 1'b0;
   endtask

   // Issue one MEM access from the current cycle, wait for mem_done (bounded),
   // return the cycle index of the done pulse, then drop the request.
   task automatic mem_access(input bit rd, input bit wr, input logic [15:0] a,
                             input logic [15:0] d, output int lat);
      bit seen;
      mem_ce = 1'b1; mem_re = rd; mem_we = wr; mem_addr_i = a; mem_data_i = d;
      seen = 1'b0;
      lat  = -1;
      for (int c = 0; c < 30; c++) begin
         if (c > 0) nxt();
         smp();
         if (mem_done === 1'b1) begin
            lat  = c;
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("mem_done_timeout", 32'd0, 32'd1);
      nxt();
      idle_inputs();
   endtask

   logic [15:0] ref_mem [int];
   logic [15:0] last_load;
   int          lat;
   int          done_cnt;

   function automatic logic [15:0] ref_read(input logic [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_pat(a);
   endfunction

   initial begin
      rst = 1'b1;
      pc  = 16'h0010;
      idle_inputs();

      // ---- Idle fetch, with reset values checked in cycle 0 ----
      reset_dut();
      smp();
      check("rst_inst_o",     {16'd0, inst_o},     32'h0);
      check("rst_mem_data_o", {16'd0, mem_data_o}, 32'h0);
      check("rst_addr",       {14'd0, ram2_addr},  32'h0);
      check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_mem_done",   {31'd0, mem_done},   32'd0);
      check("rst_strobes",    {29'd0, ram2_en_n, ram2_oe_n, ram2_we_n}, 32'h7);
      check("fetch_c0_stall", {31'd0, stall_req},  32'd0);
      for (int c = 1; c <= 2; c++) begin
         nxt(); smp();
         check("fetch_addr", {14'd0, ram2_addr}, 32'h00010);
         check("fetch_oe_n", {30'd0, ram2_en_n, ram2_oe_n}, 32'd0);
         check("fetch_stall", {31'd0, stall_req}, 32'd1);
      end
      nxt(); smp();
      check("fetch_valid_c3", {31'd0, inst_valid}, 32'd1);
      check("fetch_inst_c3",  {16'd0, inst_o},     32'h6911);
      check("fetch_oe_off",   {31'd0, ram2_oe_n},  32'd1);

      // ---- Load 0x0123 ----
      reset_dut();
      mem_ce = 1'b1; mem_re = 1'b1; mem_addr_i = 16'h0123;
      for (int c = 0; c <= 3; c++) begin
         if (c > 0) nxt();
         smp();
         check("load_stall", {31'd0, stall_req}, {31'd0, (c < 3)});
         check("load_done",  {31'd0, mem_done},  {31'd0, (c == 3)});
      end
      check("load_data", {16'd0, mem_data_o}, 32'hBEEF);
      nxt();
      idle_inputs();
      smp();
      check("load_no_retrigger_en", {31'd0, ram2_en_n}, 32'd1);
      check("load_no_retrigger_done", {31'd0, mem_done}, 32'd0);

      // ---- Store 0x0456 <= 0x1234, then read back ----
      reset_dut();
      mem_ce = 1'b1; mem_we = 1'b1; mem_addr_i = 16'h0456; mem_data_i = 16'h1234;
      for (int c = 0; c <= 4; c++) begin
         if (c > 0) nxt();
         smp();
         check("store_we_n", {31'd0, ram2_we_n}, {31'd0, (c != 2)});
         check("store_done", {31'd0, mem_done},  {31'd0, (c == 4)});
         if (c >= 1 && c <= 3) begin
            check("store_bus",  {16'd0, ram2_data}, 32'h1234);
            check("store_oe_n", {31'd0, ram2_oe_n}, 32'd1);
            check("store_addr", {14'd0, ram2_addr}, 32'h00456);
         end
      end
      nxt();
      idle_inputs();
      mem_access(1'b1, 1'b0, 16'h0456, 16'h0, lat);
      check("store_readback", {16'd0, mem_data_o}, 32'h1234);

      // ---- re and we together: must write ----
      reset_dut();
      mem_access(1'b1, 1'b1, 16'h0007, 16'hCAFE, lat);
      check("rw_latency", lat, WR_LAT);
      check("rw_no_load", {16'd0, mem_data_o}, 32'h0);
      mem_access(1'b1, 1'b0, 16'h0007, 16'h0, lat);
      check("rw_readback", {16'd0, mem_data_o}, 32'hCAFE);

      // ---- MEM request arrives mid-fetch ----
      reset_dut();
      smp();
      nxt();
      mem_ce = 1'b1; mem_re = 1'b1; mem_addr_i = 16'h0123;
      smp();
      check("mid_stall_c1", {31'd0, stall_req}, 32'd1);
      nxt(); smp();
      check("mid_valid_c2", {31'd0, inst_valid}, 32'd0);
      nxt(); smp();
      check("mid_valid_c3", {31'd0, inst_valid}, 32'd1);
      check("mid_done_c3",  {31'd0, mem_done},   32'd0);
      check("mid_stall_c3", {31'd0, stall_req},  32'd1);
      nxt(); smp();
      check("mid_addr_c4", {14'd0, ram2_addr}, 32'h00123);
      nxt(); smp();
      nxt(); smp();
      check("mid_done_c6", {31'd0, mem_done},   32'd1);
      check("mid_data_c6", {16'd0, mem_data_o}, 32'hBEEF);
      nxt();
      idle_inputs();

      // ---- Reset during the write pulse ----
      reset_dut();
      mem_ce = 1'b1; mem_we = 1'b1; mem_addr_i = 16'h0300; mem_data_i = 16'h5555;
      smp();
      nxt(); smp();
      nxt();
      rst = 1'b1;
      idle_inputs();
      smp();
      check("abort_we_low", {31'd0, ram2_we_n}, 32'd0);
      nxt();
      rst = 1'b0;
      smp();
      check("abort_we_n",  {31'd0, ram2_we_n}, 32'd1);
      check("abort_en_n",  {31'd0, ram2_en_n}, 32'd1);
      check("abort_stall", {31'd0, stall_req}, 32'd0);
      done_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (mem_done === 1'b1) done_cnt++;
         nxt(); smp();
      end
      check("abort_no_done", done_cnt, 0);

      // ---- Randomized loads/stores against the reference memory ----
      reset_dut();
      last_load = 16'h0;
      for (int i = 0; i < 40; i++) begin
         int          op;
         int          gap;
         logic [15:0] a;
         logic [15:0] d;
         op  = int'($urandom_range(0, 2));
         gap = int'($urandom_range(0, 3));
         a   = 16'h1000 + 16'($urandom_range(0, 15));
         d   = 16'($urandom);
         for (int g = 0; g < gap; g++) nxt();
         if (op == 0) begin
            mem_access(1'b1, 1'b0, a, d, lat);
            last_load = ref_read(a);
            check("rnd_load_data", {16'd0, mem_data_o}, {16'd0, last_load});
            check("rnd_load_lat", {31'd0, (lat >= RD_LAT && lat <= RD_LAT + RD_WAIT + 1)}, 32'd1);
         end else begin
            mem_access(op == 2, 1'b1, a, d, lat);
            ref_mem[int'(a)] = d;
            check("rnd_store_hold", {16'd0, mem_data_o}, {16'd0, last_load});
            check("rnd_store_lat", {31'd0, (lat >= WR_LAT && lat <= WR_LAT + RD_WAIT + 1)}, 32'd1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
